// File: rtl/pi_cmd_initiator.sv
// Pi-side initiator of the candy-dispense command interface: drives the
// state/amount codes and candy_flag, then completes a two-edge handshake.
module pi_cmd_initiator #(
  parameter int unsigned SETUP_CYC   = 4,
  parameter int unsigned TIMEOUT_CYC = 2080000,
  parameter int unsigned CNT_W       = 21
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] req_state,
  input  logic [1:0] req_amount,
  input  logic       handshake_in,
  output logic [2:0] cmd_state,
  output logic [1:0] cmd_amount,
  output logic       candy_flag,
  output logic       busy,
  output logic       done,
  output logic [1:0] err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ASSERT,
    S_RELEASE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_AMOUNT  = 2'b01;
  localparam logic [1:0] ERR_ACK     = 2'b10;
  localparam logic [1:0] ERR_RELEASE = 2'b11;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]       cmd_state_q, cmd_state_d;
  logic [1:0]       cmd_amount_q, cmd_amount_d;
  logic             candy_flag_q, candy_flag_d;
  logic             done_q, done_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [1:0]       sync_q;
  logic             hs_s;
  logic             accept;

  assign hs_s = sync_q[1];

  // Saturating so a long stale ack can never wrap back below the compare values.
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cmd_state_q  <= '0;
      cmd_amount_q <= '0;
      candy_flag_q <= 1'b0;
      done_q       <= 1'b0;
      err_code_q   <= ERR_NONE;
      sync_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_state_q  <= cmd_state_d;
      cmd_amount_q <= cmd_amount_d;
      candy_flag_q <= candy_flag_d;
      done_q       <= done_d;
      err_code_q   <= err_code_d;
      sync_q       <= {sync_q[0], handshake_in};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_inc;
    err_code_d = err_code_q;
    accept     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          if (req_amount == 2'b11) begin
            err_code_d = ERR_AMOUNT;
          end else begin
            accept     = 1'b1;
            err_code_d = ERR_NONE;
            state_d    = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        // >= lets a stale ack that clears late still proceed straight to ASSERT.
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!hs_s && (cnt_q >= SETUP_LAST)) begin
          state_d = S_ASSERT;
          cnt_d   = '0;
        end else if (hs_s && (cnt_q == TIMEOUT_LAST)) begin
          state_d    = S_ERR;
          err_code_d = ERR_RELEASE;
        end
      end
      S_ASSERT: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (hs_s) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d    = S_ERR;
          err_code_d = ERR_ACK;
        end
      end
      S_RELEASE: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (!hs_s) begin
          state_d = S_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d    = S_ERR;
          err_code_d = ERR_RELEASE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      S_ERR: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line up with it.
  always_comb begin
    cmd_state_d  = accept ? req_state  : cmd_state_q;
    cmd_amount_d = accept ? req_amount : cmd_amount_q;
    candy_flag_d = (state_d == S_ASSERT);
    done_d       = (state_d == S_DONE);
  end

  assign cmd_state  = cmd_state_q;
  assign cmd_amount = cmd_amount_q;
  assign candy_flag = candy_flag_q;
  assign done       = done_q;
  assign err_code   = err_code_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_pi_cmd_initiator.sv
// Directed bench for pi_cmd_initiator: cycle-exact checks of the handshake,
// timeouts, illegal amount, abort and mid-transaction reset.
module tb_pi_cmd_initiator;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start;
  logic       abort;
  logic [2:0] req_state;
  logic [1:0] req_amount;
  logic       handshake_in;
  logic [2:0] cmd_state;
  logic [1:0] cmd_amount;
  logic       candy_flag;
  logic       busy;
  logic       done;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  pi_cmd_initiator #(
    .SETUP_CYC  (4),
    .TIMEOUT_CYC(50),
    .CNT_W      (21)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .abort       (abort),
    .req_state   (req_state),
    .req_amount  (req_amount),
    .handshake_in(handshake_in),
    .cmd_state   (cmd_state),
    .cmd_amount  (cmd_amount),
    .candy_flag  (candy_flag),
    .busy        (busy),
    .done        (done),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rstn && done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0;
    req_state = 3'b000; req_amount = 2'b00; handshake_in = 1'b1;

    // Reset with handshake high
    tick(3);
    check("rst_cmd_state", cmd_state, 0);
    check("rst_cmd_amount", cmd_amount, 0);
    check("rst_flag", candy_flag, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_code, 0);
    check("rst_sync", dut.hs_s, 0);
    rstn = 1'b1;
    tick(1);
    check("sync_stage1", dut.hs_s, 0);
    tick(1);
    check("sync_stage2", dut.hs_s, 1);
    check("sync_busy", busy, 0);
    check("sync_flag", candy_flag, 0);
    handshake_in = 1'b0;
    tick(3);
    $display("txn reset: outputs idle, sync latency 2");

    // Normal transaction
    start = 1'b1; req_state = 3'b101; req_amount = 2'b01;
    tick(1);
    start = 1'b0;
    check("ok_cmd_state", cmd_state, 3'b101);
    check("ok_cmd_amount", cmd_amount, 2'b01);
    check("ok_busy", busy, 1);
    check("ok_flag_setup", candy_flag, 0);
    tick(3);
    check("ok_flag_setup_end", candy_flag, 0);
    tick(1);
    check("ok_flag_rise", candy_flag, 1);
    tick(5);
    handshake_in = 1'b1;
    tick(2);
    check("ok_flag_before_ack", candy_flag, 1);
    tick(1);
    check("ok_flag_fall", candy_flag, 0);
    check("ok_busy_release", busy, 1);
    tick(2);
    handshake_in = 1'b0;
    tick(2);
    check("ok_done_early", done, 0);
    tick(1);
    check("ok_done", done, 1);
    check("ok_err", err_code, 0);
    tick(1);
    check("ok_done_off", done, 0);
    check("ok_idle", busy, 0);
    check("ok_cmd_hold", cmd_state, 3'b101);
    $display("txn normal: state=101 amount=01 done");

    // Illegal amount, then legal start with no ack
    start = 1'b1; req_state = 3'b010; req_amount = 2'b11;
    tick(1);
    start = 1'b0;
    check("ill_err", err_code, 2'b01);
    check("ill_busy", busy, 0);
    check("ill_flag", candy_flag, 0);
    check("ill_amount_hold", cmd_amount, 2'b01);
    tick(1);
    check("ill_busy2", busy, 0);
    $display("txn illegal amount: err=01");

    start = 1'b1; req_state = 3'b011; req_amount = 2'b10;
    tick(1);
    check("noack_err_clr", err_code, 0);
    check("noack_busy", busy, 1);
    check("noack_amount", cmd_amount, 2'b10);
    req_state = 3'b110; req_amount = 2'b00;
    tick(1);
    start = 1'b0;
    tick(3);
    check("noack_flag_rise", candy_flag, 1);
    check("busy_start_ignored", cmd_state, 3'b011);
    tick(49);
    check("noack_flag_last", candy_flag, 1);
    tick(1);
    check("noack_flag_drop", candy_flag, 0);
    check("noack_err", err_code, 2'b10);
    check("noack_busy_err", busy, 1);
    check("noack_done", done, 0);
    tick(1);
    check("noack_idle", busy, 0);
    tick(1);
    check("noack_idle2", busy, 0);
    check("noack_err_hold", err_code, 2'b10);
    $display("txn no ack: err=10");

    // Release timeout with handshake held high
    start = 1'b1; req_state = 3'b111; req_amount = 2'b00;
    tick(1);
    start = 1'b0;
    tick(4);
    check("rel_flag_rise", candy_flag, 1);
    handshake_in = 1'b1;
    tick(2);
    check("rel_flag_hold", candy_flag, 1);
    tick(1);
    check("rel_flag_fall", candy_flag, 0);
    tick(49);
    check("rel_busy_wait", busy, 1);
    check("rel_err_wait", err_code, 0);
    tick(1);
    check("rel_err", err_code, 2'b11);
    check("rel_busy_err", busy, 1);
    tick(1);
    check("rel_idle", busy, 0);
    check("rel_done", done, 0);
    $display("txn release timeout: err=11");

    // Stale ack holds SETUP, then abort as ack arrives
    start = 1'b1; req_state = 3'b001; req_amount = 2'b10;
    tick(1);
    start = 1'b0;
    check("stale_err_clr", err_code, 0);
    check("stale_busy", busy, 1);
    tick(10);
    check("stale_flag_wait", candy_flag, 0);
    handshake_in = 1'b0;
    tick(2);
    check("stale_flag_wait2", candy_flag, 0);
    tick(1);
    check("stale_flag_rise", candy_flag, 1);
    handshake_in = 1'b1;
    tick(2);
    check("abort_flag_pre", candy_flag, 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_flag", candy_flag, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err_code, 0);
    tick(1);
    check("abort_idle", busy, 0);
    $display("txn stale ack + abort");

    // Reset in the middle of ASSERT
    handshake_in = 1'b0;
    tick(3);
    start = 1'b1; req_state = 3'b100; req_amount = 2'b01;
    tick(1);
    start = 1'b0;
    tick(4);
    check("mid_flag_rise", candy_flag, 1);
    tick(2);
    rstn = 1'b0;
    tick(1);
    check("mid_rst_flag", candy_flag, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cmd", cmd_state, 0);
    check("mid_rst_amount", cmd_amount, 0);
    rstn = 1'b1;
    tick(2);
    $display("txn reset mid-assert");

    check("done_pulses", done_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
